dst_hazard_unit: RTL and testbench

// - Tracks the destination register number (rt/rd, already selected in ID) through the EX, MEM and WB stages.
// - Compares the tracked numbers against the ID-stage source registers.
// - Raises a load-use stall, and produces registered forwarding selects for the instruction entering EX.
// - Sits between decode/control and the EX-stage operand muxes; also supplies the register-file write address and enable.

---
 rtl/dst_hazard_unit_if.sv | 20 ++
 rtl/dst_hazard_unit.sv | 65 ++++++
 tb/tb_dst_hazard_unit.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/dst_hazard_unit_if.sv
// dst_hazard_unit_if: ID-side request, stall/forward selects and write-back port of the hazard unit
interface dst_hazard_unit_if #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
);
    logic              id_valid, id_use_rs, id_use_rt, id_we, id_load, flush;
    logic [ADDR_W-1:0] id_rs, id_rt, id_dst;
    logic              stall, wb_we;
    logic [1:0]        ex_fwd_rs, ex_fwd_rt;
    logic [ADDR_W-1:0] wb_dst;
    logic [CNT_W-1:0]  stall_count;
    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dst, id_we, id_load, flush,
        input  stall, ex_fwd_rs, ex_fwd_rt, wb_dst, wb_we, stall_count
    );
    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dst, id_we, id_load, flush,
        output stall, ex_fwd_rs, ex_fwd_rt, wb_dst, wb_we, stall_count
    );
endinterface

// File: rtl/dst_hazard_unit.sv
// dst_hazard_unit: EX/MEM/WB destination tracking, load-use stall, forwarding selects; HAZ_STATS_EN adds a saturating stall counter
module dst_hazard_unit #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input logic             clk,
    input logic             rst_n,
    dst_hazard_unit_if.slave bus
);
    typedef struct packed {
        logic              we;
        logic              load;
        logic [ADDR_W-1:0] dst;
    } stage_t;
    stage_t     ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic [1:0] fwd_rs_q, fwd_rs_d, fwd_rt_q, fwd_rt_d;
    logic       ex_eff, mem_eff, stall, accept;
    always_comb begin
        ex_eff   = ex_q.we && ex_q.dst != '0;
        mem_eff  = mem_q.we && mem_q.dst != '0;
        stall    = bus.id_valid && !bus.flush && ex_q.load && ex_eff &&
                   ((bus.id_use_rs && ex_q.dst == bus.id_rs) || (bus.id_use_rt && ex_q.dst == bus.id_rt));
        accept   = bus.id_valid && !bus.flush && !stall;
        ex_d     = accept ? {bus.id_we, bus.id_load, bus.id_dst} : '0;
        mem_d    = ex_q;
        wb_d     = mem_q;
        fwd_rs_d = !(accept && bus.id_use_rs)         ? 2'b00 :
                   ex_eff && ex_q.dst == bus.id_rs    ? 2'b01 :
                   mem_eff && mem_q.dst == bus.id_rs  ? 2'b10 : 2'b00;
        fwd_rt_d = !(accept && bus.id_use_rt)         ? 2'b00 :
                   ex_eff && ex_q.dst == bus.id_rt    ? 2'b01 :
                   mem_eff && mem_q.dst == bus.id_rt  ? 2'b10 : 2'b00;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q     <= '0;
            mem_q    <= '0;
            wb_q     <= '0;
            fwd_rs_q <= 2'b00;
            fwd_rt_q <= 2'b00;
        end else begin
            ex_q     <= ex_d;
            mem_q    <= mem_d;
            wb_q     <= wb_d;
            fwd_rs_q <= fwd_rs_d;
            fwd_rt_q <= fwd_rt_d;
        end
    end
    assign bus.stall     = stall;
    assign bus.ex_fwd_rs = fwd_rs_q;
    assign bus.ex_fwd_rt = fwd_rt_q;
    assign bus.wb_dst    = wb_q.dst;
    assign bus.wb_we     = wb_q.we && wb_q.dst != '0;
`ifdef HAZ_STATS_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = stall && cnt_q != '1 ? cnt_q + CNT_W'(1) : cnt_q;
    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
    assign bus.stall_count = cnt_q;
`else
    assign bus.stall_count = '0;
`endif
endmodule

// File: tb/tb_dst_hazard_unit.sv
// tb_dst_hazard_unit: directed scenarios plus random traffic checked against an issue-history reference model
module tb_dst_hazard_unit;
    localparam int AW   = 5;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;
    typedef struct {
        logic          we;
        logic          load;
        logic [AW-1:0] dst;
    } slot_t;
    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    int    checks = 0;
    int    errors = 0;
    slot_t hist[$];
    logic [1:0] efr = 2'b00, eft = 2'b00;
    int    nstall = 0;
    bit    known = 0, m_stall = 0;
    logic  o_stall;
    dst_hazard_unit_if #(.ADDR_W(AW), .CNT_W(CW)) bus ();
    dst_hazard_unit #(.ADDR_W(AW), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    function automatic bit eff(slot_t s);
        return s.we && s.dst != 0;
    endfunction
    function automatic bit reads(logic [AW-1:0] r);
        return (bus.id_use_rs && bus.id_rs == r) || (bus.id_use_rt && bus.id_rt == r);
    endfunction
    function automatic bit model_stall();
        return bus.id_valid && !bus.flush && hist[0].load && eff(hist[0]) && reads(hist[0].dst);
    endfunction
    // youngest in-flight producer of r wins; WB is covered by the write-first register file
    function automatic logic [1:0] fsel(logic u, logic [AW-1:0] r);
        if (!u) return 2'b00;
        if (eff(hist[0]) && hist[0].dst == r) return 2'b01;
        if (eff(hist[1]) && hist[1].dst == r) return 2'b10;
        return 2'b00;
    endfunction
    function automatic logic [31:0] exp_cnt();
`ifdef HAZ_STATS_EN
        return nstall > CMAX ? CMAX : nstall;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        slot_t z, n;
        bit acc;
        z = '{we: 1'b0, load: 1'b0, dst: '0};
        #1;
        m_stall = known && rst_n && model_stall();
        o_stall = bus.stall;
        if (known && rst_n) chk("stall", 32'(bus.stall), 32'(m_stall));
        @(posedge clk);
        if (!rst_n) begin
            hist = '{z, z, z};
            efr = 2'b00;
            eft = 2'b00;
            nstall = 0;
            known = 1;
        end else begin
            acc = bus.id_valid && !bus.flush && !m_stall;
            efr = acc ? fsel(bus.id_use_rs, bus.id_rs) : 2'b00;
            eft = acc ? fsel(bus.id_use_rt, bus.id_rt) : 2'b00;
            if (m_stall) nstall++;
            n = z;
            if (acc) n = '{we: bus.id_we, load: bus.id_load, dst: bus.id_dst};
            hist.push_front(n);
            hist = hist[0:2];
        end
        #1;
        if (known) begin
            chk("ex_fwd_rs", 32'(bus.ex_fwd_rs), 32'(efr));
            chk("ex_fwd_rt", 32'(bus.ex_fwd_rt), 32'(eft));
            chk("wb_we", 32'(bus.wb_we), 32'(eff(hist[2])));
            chk("wb_dst", 32'(bus.wb_dst), 32'(hist[2].dst));
            chk("stall_count", 32'(bus.stall_count), exp_cnt());
        end
    endtask

    task automatic set(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                       input logic urs, input logic urt, input logic [AW-1:0] dst,
                       input logic we, input logic ld, input logic fl);
        bus.id_valid = v;  bus.id_rs = rs;  bus.id_rt = rt;
        bus.id_use_rs = urs;  bus.id_use_rt = urt;  bus.id_dst = dst;
        bus.id_we = we;  bus.id_load = ld;  bus.flush = fl;
    endtask

    task automatic rnd(input int hi);
        set(1'($urandom_range(0, 4) != 0), AW'($urandom_range(0, hi)), AW'($urandom_range(0, hi)),
            1'($urandom), 1'($urandom), AW'($urandom_range(0, hi)),
            1'($urandom), 1'($urandom), 1'($urandom_range(0, 9) == 0));
    endtask

    task automatic nop(input int k);
        set(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (k) cyc();
    endtask

    // presents one instruction and holds it in ID for as long as the DUT stalls it
    task automatic issue(input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic urs,
                         input logic urt, input logic [AW-1:0] dst, input logic we,
                         input logic ld, input logic fl, output int n);
        set(1, rs, rt, urs, urt, dst, we, ld, fl);
        n = 0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (o_stall !== 1'b1) break;
            n++;
        end
        if (o_stall === 1'b1) begin
            checks++;
            errors++;
            $error("FAIL stall_bound: observed stall still 1 after 4 cycles expected release");
        end
    endtask

    initial begin
        int n;
        set(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (2) begin rnd(31); cyc(); end
        rst_n = 1'b1;
        #1;
        chk("rst_stall", 32'(bus.stall), 0);
        chk("rst_fwd_rs", 32'(bus.ex_fwd_rs), 0);
        chk("rst_fwd_rt", 32'(bus.ex_fwd_rt), 0);
        chk("rst_wb_we", 32'(bus.wb_we), 0);
        chk("rst_wb_dst", 32'(bus.wb_dst), 0);
        nop(3);
        // lw $8 ; add $10,$8,$9
        issue(1, 0, 1, 0, 8, 1, 1, 0, n);
        issue(8, 9, 1, 1, 10, 1, 0, 0, n);
        chk("lu_stall_cycles", 32'(n), 1);
        chk("lu_fwd_rs", 32'(bus.ex_fwd_rs), 2);
        chk("lu_fwd_rt", 32'(bus.ex_fwd_rt), 0);
        nop(1);
        chk("lu_bubble_wb_we", 32'(bus.wb_we), 0);
        nop(1);
        chk("lu_add_wb_we", 32'(bus.wb_we), 1);
        chk("lu_add_wb_dst", 32'(bus.wb_dst), 10);
        nop(3);
        // add $9 ; sub $11,$4,$9 with 0, 1 and 2 gaps
        issue(1, 2, 1, 1, 9, 1, 0, 0, n);
        issue(4, 9, 1, 1, 11, 1, 0, 0, n);
        chk("alu_nostall", 32'(n), 0);
        chk("alu_fwd_rt_gap0", 32'(bus.ex_fwd_rt), 1);
        chk("alu_fwd_rs_gap0", 32'(bus.ex_fwd_rs), 0);
        nop(3);
        issue(1, 2, 1, 1, 9, 1, 0, 0, n);
        nop(1);
        issue(4, 9, 1, 1, 11, 1, 0, 0, n);
        chk("alu_fwd_rt_gap1", 32'(bus.ex_fwd_rt), 2);
        nop(3);
        issue(1, 2, 1, 1, 9, 1, 0, 0, n);
        nop(2);
        issue(4, 9, 1, 1, 11, 1, 0, 0, n);
        chk("alu_fwd_rt_gap2", 32'(bus.ex_fwd_rt), 0);
        nop(3);
        // two producers of $5: youngest wins
        issue(1, 2, 1, 1, 5, 1, 0, 0, n);
        issue(3, 2, 1, 1, 5, 1, 0, 0, n);
        issue(5, 0, 1, 0, 12, 1, 0, 0, n);
        chk("youngest_fwd_rs", 32'(bus.ex_fwd_rs), 1);
        nop(3);
        // lw $0 never stalls, forwards or writes
        issue(2, 0, 1, 0, 0, 1, 1, 0, n);
        issue(0, 0, 1, 1, 13, 1, 0, 0, n);
        chk("r0_nostall", 32'(n), 0);
        chk("r0_fwd_rs", 32'(bus.ex_fwd_rs), 0);
        chk("r0_fwd_rt", 32'(bus.ex_fwd_rt), 0);
        nop(1);
        chk("r0_wb_we", 32'(bus.wb_we), 0);
        nop(3);
        // load-use killed by flush, then a plain flushed write
        issue(1, 0, 1, 0, 8, 1, 1, 0, n);
        issue(8, 0, 1, 0, 14, 1, 0, 1, n);
        chk("flush_nostall", 32'(n), 0);
        chk("flush_fwd_rs", 32'(bus.ex_fwd_rs), 0);
        issue(1, 2, 1, 1, 12, 1, 0, 1, n);
        nop(2);
        chk("flush_wb_we", 32'(bus.wb_we), 0);
        nop(3);
        // chain of lw $8,($8): one stall per link
        repeat (21) issue(8, 0, 1, 0, 8, 1, 1, 0, n);
        chk("cnt_sat", 32'(bus.stall_count), exp_cnt());
        repeat (3) issue(8, 0, 1, 0, 8, 1, 1, 0, n);
`ifdef HAZ_STATS_EN
        chk("cnt_hold", 32'(bus.stall_count), CMAX);
`else
        chk("cnt_zero", 32'(bus.stall_count), 0);
`endif
        // reset with writes in flight
        issue(1, 2, 1, 1, 3, 1, 0, 0, n);
        issue(1, 2, 1, 1, 4, 1, 0, 0, n);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("midrst_wb_we0", 32'(bus.wb_we), 0);
        chk("midrst_cnt", 32'(bus.stall_count), 0);
        nop(1);
        chk("midrst_wb_we1", 32'(bus.wb_we), 0);
        nop(1);
        chk("midrst_wb_we2", 32'(bus.wb_we), 0);
        // random traffic over a small register set to provoke hazards
        for (int i = 0; i < 400; i++) begin
            rnd(3);
            rst_n = 1'($urandom_range(0, 63) != 0);
            cyc();
        end
        rst_n = 1'b1;
        nop(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
